mips_bus_arbiter: RTL

Parametrised, multi-port memory arbiter for the 5-stage MIPS pipeline. It merges N core-side access ports onto one shared multi-cycle memory bus with request/acknowledge handshaking. Port 0 is instruction fetch and port 1 is load/store. Per-port stall outputs feed the pipeline controller, so the core freezes until each of its accesses completes. Arbitration is round-robin, and an optional watchdog aborts hung bus cycles.

---
 rtl/mips_bus_arbiter_if.sv | 29 ++
 rtl/mips_bus_arbiter.sv | 109 ++++++++++
 2 files changed

// File: rtl/mips_bus_arbiter_if.sv
// mips_bus_arbiter_if: core-side access ports and shared memory bus of mips_bus_arbiter.
//   port_ren/port_wen  per-port level read/write requests
//   port_addr/wdata    packed per-port address / write data (port i at [i*W +: W])
//   port_rdata         packed registered read data
//   port_stall/done    per-port pipeline stall and one-cycle completion pulse
//   bus_req/we/addr/wdata  shared bus cycle request, held stable while busy
//   bus_ack/rdata      slave completion and read data
//   bus_err            sticky watchdog timeout flag
// Modport master is the arbiter's view; slave is the core/memory environment's view.
interface mips_bus_arbiter_if #(
    parameter int N_PORTS = 2,
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [N_PORTS-1:0] port_ren, port_wen, port_stall, port_done;
    logic [N_PORTS*AW-1:0] port_addr;
    logic [N_PORTS*DW-1:0] port_wdata, port_rdata;
    logic bus_req, bus_we, bus_ack, bus_err;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata, bus_rdata;
    modport master (
        input port_ren, port_wen, port_addr, port_wdata, bus_ack, bus_rdata,
        output port_rdata, port_stall, port_done, bus_req, bus_we, bus_addr, bus_wdata, bus_err
    );
    modport slave (
        output port_ren, port_wen, port_addr, port_wdata, bus_ack, bus_rdata,
        input port_rdata, port_stall, port_done, bus_req, bus_we, bus_addr, bus_wdata, bus_err
    );
endinterface

// File: rtl/mips_bus_arbiter.sv
// mips_bus_arbiter: round-robin arbiter merging N core ports onto one multi-cycle memory bus.
//   clk    main clock
//   rst_n  asynchronous active-low reset
//   bus    mips_bus_arbiter_if.master carrying all port-side and bus-side signals
// Optional watchdog: define MIPS_BUS_TIMEOUT_EN to abort bus cycles after TIMEOUT
// ack-less busy cycles (read returns all ones, bus_err sets sticky).
module mips_bus_arbiter #(
    parameter int N_PORTS = 2,
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int TIMEOUT = 255
) (
    input logic clk,
    input logic rst_n,
    mips_bus_arbiter_if.master bus
);
    localparam int IW = N_PORTS > 1 ? $clog2(N_PORTS) : 1;
    localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;
    logic [1:0] state;
    logic [IW-1:0] rr_ptr, grant, next_grant, idx;
    logic found, abort, we_q;
    logic [N_PORTS-1:0] pending, done;
    logic [AW-1:0] addr_a [N_PORTS];
    logic [DW-1:0] wdata_a [N_PORTS];
    logic [DW-1:0] rdata [N_PORTS];
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    assign pending = bus.port_ren | bus.port_wen;
    always_comb begin
        for (int k = 0; k < N_PORTS; k++) begin
            addr_a[k] = bus.port_addr[k*AW +: AW];
            wdata_a[k] = bus.port_wdata[k*DW +: DW];
            bus.port_rdata[k*DW +: DW] = rdata[k];
        end
    end
    // first pending port at or above rr_ptr, wrapping
    always_comb begin
        found = 1'b0;
        next_grant = rr_ptr;
        idx = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            idx = IW'((int'(rr_ptr) + k) % N_PORTS);
            if (!found && pending[idx]) begin
                found = 1'b1;
                next_grant = idx;
            end
        end
    end
    always_comb begin
        for (int k = 0; k < N_PORTS; k++) done[k] = state == DONE && grant == IW'(k);
    end
    assign bus.port_done = done;
    assign bus.port_stall = pending & ~done;
    assign bus.bus_req = state == BUSY;
    assign bus.bus_we = we_q;
    assign bus.bus_addr = addr_q;
    assign bus.bus_wdata = wdata_q;
`ifdef MIPS_BUS_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wd_cnt;
    logic err_q;
    // wd_cnt holds the number of BUSY cycles already spent; an ack on the last one still wins
    assign abort = state == BUSY && !bus.bus_ack && wd_cnt == CW'(TIMEOUT - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
            err_q <= 1'b0;
        end else begin
            wd_cnt <= state == BUSY ? wd_cnt + 1'b1 : '0;
            if (abort) err_q <= 1'b1;
        end
    end
    assign bus.bus_err = err_q;
`else
    localparam int unused_timeout = TIMEOUT;
    assign abort = 1'b0;
    assign bus.bus_err = 1'b0;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            rr_ptr <= '0;
            grant <= '0;
            we_q <= 1'b0;
            addr_q <= '0;
            wdata_q <= '0;
            for (int k = 0; k < N_PORTS; k++) rdata[k] <= '0;
        end else begin
            case (state)
                IDLE: if (found) begin
                    state <= BUSY;
                    grant <= next_grant;
                    we_q <= bus.port_wen[next_grant];
                    addr_q <= addr_a[next_grant];
                    wdata_q <= wdata_a[next_grant];
                end
                BUSY: if (bus.bus_ack || abort) begin
                    state <= DONE;
                    if (!we_q) rdata[grant] <= bus.bus_ack ? bus.bus_rdata : '1;
                end
                DONE: begin
                    state <= IDLE;
                    rr_ptr <= grant == IW'(N_PORTS - 1) ? '0 : grant + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
